// File: rtl/uart_sender_pkg.sv
// Shared UART definitions: line-state encoding, oversampling rate and frame defaults.
// Used by both the transmitter and the receiver.
package uart_sender_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int OVERSAMPLE   = 16;
   localparam int DEF_DBIT     = 8;
   localparam int DEF_SB_TICK  = 16;

   // Tick timer must hold both the per-bit count and the longest stop period.
   function automatic int tick_cnt_width(input int sb_tick);
      int w_bit;
      int w_stop;
      w_bit  = $clog2(OVERSAMPLE);
      w_stop = $clog2(sb_tick);
      return (w_stop > w_bit) ? w_stop : w_bit;
   endfunction

endpackage

// File: rtl/uart_sender.sv
// UART transmitter with a one-entry holding register so the next byte can be
// queued while the current frame is on the line; frames go out back-to-back.
//
// state | meaning
// IDLE  | line high, waiting for tx_start
// START | start bit (0) for OVERSAMPLE ticks
// DATA  | DBIT data bits, LSB first, OVERSAMPLE ticks each
// STOP  | line high for SB_TICK ticks, then next frame or IDLE
module uart_sender
   import uart_sender_pkg::*;
#(
   parameter int DBIT    = DEF_DBIT,
   parameter int SB_TICK = DEF_SB_TICK
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_tick,
   input  logic       tx_start,
   input  logic [7:0] data_in,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done_tick,
   output logic       tx
);

   localparam int              S_W         = tick_cnt_width(SB_TICK);
   localparam logic [S_W-1:0]  S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
   localparam logic [S_W-1:0]  S_STOP_LAST = S_W'(SB_TICK - 1);
   localparam logic [2:0]      N_LAST      = 3'(DBIT - 1);

   uart_state_t    state;
   logic [S_W-1:0] s_cnt;
   logic [2:0]     n_cnt;
   logic [7:0]     shift_reg;
   logic [7:0]     hold_reg;
   logic           hold_valid;
   logic           stop_done;

   // Both timers count down and fire on terminal count zero.
   assign stop_done = (state == STOP) && s_tick && (s_cnt == '0);
   assign tx_ready  = ~hold_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         s_cnt        <= '0;
         n_cnt        <= '0;
         shift_reg    <= '0;
         hold_reg     <= '0;
         hold_valid   <= 1'b0;
         tx           <= 1'b1;
         tx_busy      <= 1'b0;
         tx_done_tick <= 1'b0;
      end else begin
         // Line outputs are decoded from the current state one clk later, so
         // every bit, including the back-to-back start bit, keeps full length.
         case (state)
            START:   tx <= 1'b0;
            DATA:    tx <= shift_reg[0];
            default: tx <= 1'b1;
         endcase
         tx_busy      <= (state != IDLE);
         tx_done_tick <= stop_done;

         case (state)
            IDLE: begin
               if (tx_start) begin
                  shift_reg <= data_in;
                  s_cnt     <= S_BIT_LAST;
                  state     <= START;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s_cnt == '0) begin
                     s_cnt <= S_BIT_LAST;
                     n_cnt <= N_LAST;
                     state <= DATA;
                  end else begin
                     s_cnt <= s_cnt - 1'b1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s_cnt == '0) begin
                     shift_reg <= shift_reg >> 1;
                     if (n_cnt == '0) begin
                        s_cnt <= S_STOP_LAST;
                        state <= STOP;
                     end else begin
                        n_cnt <= n_cnt - 1'b1;
                        s_cnt <= S_BIT_LAST;
                     end
                  end else begin
                     s_cnt <= s_cnt - 1'b1;
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (s_cnt == '0) begin
                     // Held byte wins over a fresh request on the completion cycle.
                     if (hold_valid) begin
                        shift_reg  <= hold_reg;
                        hold_valid <= 1'b0;
                        s_cnt      <= S_BIT_LAST;
                        state      <= START;
                     end else if (tx_start) begin
                        shift_reg <= data_in;
                        s_cnt     <= S_BIT_LAST;
                        state     <= START;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     s_cnt <= s_cnt - 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if ((state != IDLE) && !stop_done && tx_start && !hold_valid) begin
            hold_reg   <= data_in;
            hold_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_sender.sv
// Bench for uart_sender: a line decoder pops expected bytes from a scoreboard
// queue; scenario tasks check timing, holding register, stop length and reset.
module tb_uart_sender;

   logic       clk;
   logic       reset;
   logic       s_tick;
   logic       tx_start;
   logic [7:0] data_in;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done_tick;
   logic       tx;

   logic       tx_start32;
   logic [7:0] data_in32;
   logic       tx_ready32;
   logic       tx_busy32;
   logic       tx_done32;
   logic       tx32;

   int         checks;
   int         errors;
   bit         rx_en;
   logic [7:0] exp_q[$];

   uart_sender #(.DBIT(8), .SB_TICK(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .s_tick       (s_tick),
      .tx_start     (tx_start),
      .data_in      (data_in),
      .tx_ready     (tx_ready),
      .tx_busy      (tx_busy),
      .tx_done_tick (tx_done_tick),
      .tx           (tx)
   );

   uart_sender #(.DBIT(8), .SB_TICK(32)) dut32 (
      .clk          (clk),
      .reset        (reset),
      .s_tick       (s_tick),
      .tx_start     (tx_start32),
      .data_in      (data_in32),
      .tx_ready     (tx_ready32),
      .tx_busy      (tx_busy32),
      .tx_done_tick (tx_done32),
      .tx           (tx32)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Baud tick every 4 clks, changed just after the rising edge.
   initial begin
      int ph;
      ph     = 0;
      s_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ph     = (ph + 1) % 4;
         s_tick = (ph == 0);
      end
   end

   // Line decoder: 64 clks per bit, samples mid-bit from the falling start edge.
   initial begin
      logic [7:0] b;
      logic [7:0] expv;
      logic       start_ok;
      logic       stop_ok;
      forever begin
         @(negedge clk);
         if (rx_en && tx === 1'b0) begin
            repeat (32) @(negedge clk);
            start_ok = (tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (64) @(negedge clk);
               b[i] = tx;
            end
            repeat (64) @(negedge clk);
            stop_ok = (tx === 1'b1);
            checks++;
            if (!start_ok || !stop_ok) begin
               errors++;
               $display("FAIL rx_framing: start=%b stop=%b required start=0 stop=1", !start_ok, stop_ok);
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rx_unexpected: got byte %h, required no frame", b);
            end else begin
               expv = exp_q.pop_front();
               if (b !== expv) begin
                  errors++;
                  $display("FAIL rx_byte: got %h required %h", b, expv);
               end
            end
         end
      end
   end

   task automatic tick_align();
      @(negedge clk);
      while (!s_tick) @(negedge clk);
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (tx_done_tick === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      tx_start   = 1'b0;
      data_in    = 8'h00;
      tx_start32 = 1'b0;
      data_in32  = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
      checks++;
      if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", tx_ready); end
      checks++;
      if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", tx_busy); end
      checks++;
      if (tx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", tx_done_tick); end
      checks++;
      if (tx32 !== 1'b1) begin errors++; $display("FAIL reset_tx32: got %b required 1", tx32); end
      reset = 1'b0;
   endtask

   // Exact per-clk line pattern with the request aligned to a tick cycle.
   task automatic test_single();
      logic [7:0] d;
      logic       exp_tx;
      d     = 8'h55;
      rx_en = 1'b1;
      tick_align();
      tx_start = 1'b1;
      data_in  = d;
      exp_q.push_back(d);
      for (int j = 0; j <= 700; j++) begin
         @(negedge clk);
         tx_start = 1'b0;
         if (j == 0)        exp_tx = 1'b1;
         else if (j <= 64)  exp_tx = 1'b0;
         else if (j <= 576) exp_tx = d[(j - 65) / 64];
         else               exp_tx = 1'b1;
         checks++;
         if (tx !== exp_tx) begin errors++; $display("FAIL single_tx clk %0d: got %b required %b", j, tx, exp_tx); end
         checks++;
         if (tx_done_tick !== (j == 640)) begin errors++; $display("FAIL single_done clk %0d: got %b required %b", j, tx_done_tick, (j == 640)); end
         checks++;
         if (tx_busy !== (j >= 1 && j <= 640)) begin errors++; $display("FAIL single_busy clk %0d: got %b required %b", j, tx_busy, (j >= 1 && j <= 640)); end
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL single_pending: got %0d bytes outstanding required 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      @(negedge clk);
      tx_start = 1'b1;
      data_in  = 8'hA3;
      exp_q.push_back(8'hA3);
      @(negedge clk);
      tx_start = 1'b0;
      repeat (200) @(negedge clk);
      checks++;
      if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_before: got %b required 1", tx_ready); end
      tx_start = 1'b1;
      data_in  = 8'h0F;
      exp_q.push_back(8'h0F);
      @(negedge clk);
      tx_start = 1'b0;
      checks++;
      if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_held: got %b required 0", tx_ready); end
      wait_done(1000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_done1: got no tx_done_tick required one"); end
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL b2b_stop_tail: got %b required 1", tx); end
      checks++;
      if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after: got %b required 1", tx_ready); end
      @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin errors++; $display("FAIL b2b_no_gap: got %b required 0", tx); end
      checks++;
      if (tx_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b required 1", tx_busy); end
      wait_done(1000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_done2: got no tx_done_tick required one"); end
      repeat (10) @(negedge clk);
      checks++;
      if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b required 0", tx_busy); end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d bytes outstanding required 0", exp_q.size()); end
   endtask

   task automatic test_overflow();
      bit ok;
      @(negedge clk);
      tx_start = 1'b1;
      data_in  = 8'h11;
      exp_q.push_back(8'h11);
      @(negedge clk);
      tx_start = 1'b0;
      repeat (100) @(negedge clk);
      tx_start = 1'b1;
      data_in  = 8'h22;
      exp_q.push_back(8'h22);
      @(negedge clk);
      tx_start = 1'b0;
      repeat (50) @(negedge clk);
      tx_start = 1'b1;
      data_in  = 8'hFF;
      @(negedge clk);
      tx_start = 1'b0;
      checks++;
      if (tx_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b required 0", tx_ready); end
      wait_done(1000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ovf_done1: got no tx_done_tick required one"); end
      wait_done(1000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ovf_done2: got no tx_done_tick required one"); end
      repeat (800) @(negedge clk);
      checks++;
      if (tx_busy !== 1'b0) begin errors++; $display("FAIL ovf_idle: got busy %b required 0", tx_busy); end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_pending: got %0d bytes outstanding required 0", exp_q.size()); end
   endtask

   // SB_TICK=32: stop high run between two back-to-back 0x00 frames.
   task automatic test_stop_len();
      bit ok;
      int run;
      bit last_done;
      tick_align();
      tx_start32 = 1'b1;
      data_in32  = 8'h00;
      @(negedge clk);
      tx_start32 = 1'b0;
      repeat (99) @(negedge clk);
      tx_start32 = 1'b1;
      @(negedge clk);
      tx_start32 = 1'b0;
      checks++;
      if (tx_ready32 !== 1'b0) begin errors++; $display("FAIL stop_ready: got %b required 0", tx_ready32); end
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (tx32 === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL stop_seen: got no stop high required one"); end
      run       = 0;
      last_done = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (tx32 !== 1'b1) break;
         run++;
         last_done = tx_done32;
         @(negedge clk);
      end
      checks++;
      if (run != 128) begin errors++; $display("FAIL stop_len: got %0d clks high required 128", run); end
      checks++;
      if (last_done !== 1'b1) begin errors++; $display("FAIL stop_done_pos: got %b required 1", last_done); end
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (tx_done32 === 1'b1) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL stop_done2: got no tx_done_tick required one"); end
      @(negedge clk);
      checks++;
      if (tx_busy32 !== 1'b0) begin errors++; $display("FAIL stop_idle: got busy %b required 0", tx_busy32); end
   endtask

   task automatic test_reset_mid();
      bit any_low;
      bit any_done;
      bit any_busy;
      rx_en = 1'b0;
      tick_align();
      tx_start = 1'b1;
      data_in  = 8'h5A;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (99) @(negedge clk);
      tx_start = 1'b1;
      data_in  = 8'h77;
      @(negedge clk);
      tx_start = 1'b0;
      checks++;
      if (tx_ready !== 1'b0) begin errors++; $display("FAIL rstmid_held: got ready %b required 0", tx_ready); end
      repeat (180) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b required 1", tx); end
      checks++;
      if (tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", tx_busy); end
      checks++;
      if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b required 1", tx_ready); end
      any_low  = 1'b0;
      any_done = 1'b0;
      any_busy = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if (tx !== 1'b1) any_low = 1'b1;
         if (tx_done_tick !== 1'b0) any_done = 1'b1;
         if (tx_busy !== 1'b0) any_busy = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (any_low) begin errors++; $display("FAIL rstmid_line: got tx low after reset required idle high"); end
      checks++;
      if (any_done) begin errors++; $display("FAIL rstmid_done: got tx_done_tick after reset required none"); end
      checks++;
      if (any_busy) begin errors++; $display("FAIL rstmid_restart: got busy after reset required 0"); end
      rx_en = 1'b1;
   endtask

   task automatic test_loopback();
      logic [7:0] lb[4];
      bit ok;
      lb[0] = 8'h00;
      lb[1] = 8'hFF;
      lb[2] = 8'h3C;
      lb[3] = 8'hC3;
      rx_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ok = 1'b0;
         for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) begin ok = 1'b1; break; end
         end
         checks++;
         if (!ok) begin errors++; $display("FAIL loop_ready byte %0d: got ready 0 required 1", k); end
         tx_start = 1'b1;
         data_in  = lb[k];
         exp_q.push_back(lb[k]);
         @(negedge clk);
         tx_start = 1'b0;
      end
      for (int i = 0; i < 4000; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL loop_pending: got %0d bytes outstanding required 0", exp_q.size()); end
      repeat (100) @(negedge clk);
      checks++;
      if (tx_busy !== 1'b0) begin errors++; $display("FAIL loop_idle: got busy %b required 0", tx_busy); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rx_en  = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_stop_len();
      test_reset_mid();
      test_loopback();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
